// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle adder/subtractor, SLICE bits per cycle
// Handshaked request/result; result flags registered alongside the final slice.
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  binv_r;
    logic              carry;
    logic [IW-1:0]     idx;

    logic [SLICE:0]    slice_res;
    logic [WIDTH-1:0]  sum_nxt;
    logic              last_slice;

    always_comb begin
        slice_res = {1'b0, a_r[idx*SLICE +: SLICE]}
                  + {1'b0, binv_r[idx*SLICE +: SLICE]}
                  + {{SLICE{1'b0}}, carry};
        sum_nxt = sum;
        sum_nxt[idx*SLICE +: SLICE] = slice_res[SLICE-1:0];
        last_slice = (idx == IW'(NSL - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            binv_r    <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        binv_r   <= b ^ {WIDTH{sub}};
                        carry    <= sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    sum   <= sum_nxt;
                    carry <= slice_res[SLICE];
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        // Flags use the fully assembled sum, including this slice.
                        cout      <= slice_res[SLICE];
                        ovf       <= (a_r[WIDTH-1] == binv_r[WIDTH-1]) &&
                                     (sum_nxt[WIDTH-1] != a_r[WIDTH-1]);
                        zero      <= (sum_nxt == '0);
                        neg       <= sum_nxt[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - directed table-driven bench for addsub_seq
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    int checks = 0;
    int failures = 0;

    addsub_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, accept it, and wait (bounded) for out_valid.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                            output int lat);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
        chk("in_ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{32'd5,        32'd3, 1'b0, 32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'd5,        32'd5, 1'b1, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h00000100, 32'd1, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", {28'b0, cout, ovf, zero, neg}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd4);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].cout});
            chk($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
            chk($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
            chk($sformatf("v%0d_neg", i), {31'b0, neg}, {31'b0, vecs[i].neg});
            finish_op();
        end

        // Stall in DONE while a new request is offered: must be ignored.
        start_op(32'd5, 32'd3, 1'b0, lat);
        chk("stall_latency", lat, 32'd4);
        a = 32'd100; b = 32'd200; sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_sum", sum, 32'd8);
            chk("stall_flags", {28'b0, cout, ovf, zero, neg}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op();
        chk("post_handshake_sum_kept", sum, 32'd8);
        tick();
        tick();
        chk("no_stray_result", {31'b0, out_valid}, 32'd0);
        chk("no_stray_accept", {31'b0, in_ready}, 32'd1);

        // Reset mid-CALC aborts the operation.
        a = 32'hFFFFFFFF; b = 32'd1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midcalc_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midcalc_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midcalc_rst_sum", sum, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midcalc_rst_no_pulse", {31'b0, out_valid}, 32'd0);
        end
        start_op(32'd1, 32'd1, 1'b0, lat);
        chk("after_rst_latency", lat, 32'd4);
        chk("after_rst_sum", sum, 32'd2);

        // Reset in DONE with a handshake in the same cycle: reset wins.
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("done_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("done_rst_sum", sum, 32'd0);
        chk("done_rst_in_ready", {31'b0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
